exe_stage: RTL
==============

// Module: exe_stage
// PURPOSE
//  Execute stage of the rv32i pipeline; sits between the ID/EX boundary and the memory stage.
//  Selects the operands, applies forwarding from MEM and WB, and drives the combinational ALU.
//  Resolves branches and jumps, then registers the result into the EX/MEM pipeline register.
//  Uses a valid/ready handshake on both sides and supports a flush input.
// PARAMETERS
//  XLEN     32  datapath width (RV32Consts::XLEN)
//  RADDR_W  5   register-file address width
// PORTS
//  clk             in   1        single clock
//  rst_n           in   1        asynchronous active-low reset
//  in_valid        in   1        ID/EX holds a valid instruction
//  in_ready        out  1        stage accepts the instruction this cycle
//  in_pc           in   XLEN     instruction PC
//  in_rs1_addr     in   RADDR_W  rs1 index (forwarding match)
//  in_rs2_addr     in   RADDR_W  rs2 index (forwarding match)
//  in_rs1_data     in   XLEN     rs1 value from register file
//  in_rs2_data     in   XLEN     rs2 value from register file
//  in_imm          in   XLEN     sign-extended immediate
//  in_op1_pc       in   1        1: op1=PC, 0: op1=rs1
//  in_op2_imm      in   1        1: op2=imm, 0: op2=rs2
//  in_funct        in   ALUFuncts::Type  ALU operation
//  in_br_type      in   3        0 none,1 BEQ,2 BNE,3 BLT,4 BGE,5 BLTU,6 BGEU,7 JAL/JALR
//  in_jalr         in   1        with br_type 7: target from rs1 (JALR)
//  in_rd_addr      in   RADDR_W  destination register
//  in_rd_we        in   1        destination write enable
//  fwd_mem_we      in   1        MEM-stage write pending
//  fwd_mem_rd      in   RADDR_W  MEM-stage destination
//  fwd_mem_data    in   XLEN     MEM-stage value
//  fwd_wb_we       in   1        WB-stage write pending
//  fwd_wb_rd       in   RADDR_W  WB-stage destination
//  fwd_wb_data     in   XLEN     WB-stage value
//  flush           in   1        kill in-flight instruction
//  out_valid       out  1        EX/MEM register holds a valid result
//  out_ready       in   1        memory stage consumes result
//  out_result      out  XLEN     ALU result, or PC+4 for JAL/JALR
//  out_store_data  out  XLEN     forwarded rs2 (store data)
//  out_rd_addr     out  RADDR_W  registered destination
//  out_rd_we       out  1        registered write enable
//  redirect_valid  out  1        one-cycle pulse: taken branch/jump
//  redirect_pc     out  XLEN     redirect target
// BEHAVIOUR
//  Reset: every output register = 0 (out_valid, redirect_valid, out_rd_we, data all 0).
//  in_ready = !out_valid || out_ready (combinational). accept = in_valid && in_ready && !flush.
//  Forwarding per source: MEM match wins over WB; match = we && rd==addr && addr!=0; else RF value.
//  op1 = in_op1_pc ? in_pc : fwd_rs1; op2 = in_op2_imm ? in_imm : fwd_rs2.
//  Branch compares use fwd_rs1/fwd_rs2 (signed for BLT/BGE, unsigned for BLTU/BGEU).
//  Target: pc+imm; JALR uses (fwd_rs1+imm) & ~1. All adds are mod 2^XLEN.
//  Latency: 1 cycle. On accept, the EX/MEM register loads and out_valid=1 next cycle.
//  On accept, redirect_valid/redirect_pc load together with the result and pulse for exactly one cycle.
//  Redirect is never held during a stall.
//  Stall (out_valid && !out_ready): all outputs hold, redirect_valid = 0.
//  out_valid && out_ready && !accept: out_valid -> 0.
//  Accept and drain in the same cycle: the new result replaces the old one with no bubble.
//  flush: out_valid -> 0 and redirect_valid -> 0 next cycle, overriding accept and drain.
//  Reset mid-operation: asynchronous clear to reset values, no partial output.
//  x0 write: out_rd_we is passed through; the register file ignores rd=0.
// TESTING
//  ADD, rs1=x5, MEM rd=5 0x10, WB rd=5 0x20, RF 0x30, rs2 imm 1 -> out_result=0x11.
//  rs1=x0, MEM rd=0 we=1 data 0xFF -> no forwarding, op1=0.
//  out_ready=0 for 3 cycles with a new in_valid -> in_ready=0, outputs stable, single redirect pulse.
//  BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=-8 -> redirect_valid=1, redirect_pc=0xF8.
//  BLTU with the same operands -> redirect_valid=0.
//  JALR, rs1=0x1001, imm=4, pc=0x40 -> redirect_pc=0x1004, out_result=0x44.
//  flush asserted in the cycle of accept -> out_valid=0, redirect_valid=0 next cycle.
//  rst_n dropped mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/exe_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// The result and the redirect are registered together, with valid/ready handshakes on both sides.
module exe_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [RADDR_W-1:0] in_rs1_addr,
    input  logic [RADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic               in_op1_pc,
    input  logic               in_op2_imm,
    input  logic [3:0]         in_funct,
    input  logic [2:0]         in_br_type,
    input  logic               in_jalr,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic               in_rd_we,
    input  logic               fwd_mem_we,
    input  logic [RADDR_W-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]    fwd_mem_data,
    input  logic               fwd_wb_we,
    input  logic [RADDR_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]    fwd_wb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [XLEN-1:0]    out_store_data,
    output logic [RADDR_W-1:0] out_rd_addr,
    output logic               out_rd_we,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    // ALU operation encoding
    localparam logic [3:0] FnAdd  = 4'd0;
    localparam logic [3:0] FnSub  = 4'd1;
    localparam logic [3:0] FnSll  = 4'd2;
    localparam logic [3:0] FnSlt  = 4'd3;
    localparam logic [3:0] FnSltu = 4'd4;
    localparam logic [3:0] FnXor  = 4'd5;
    localparam logic [3:0] FnSrl  = 4'd6;
    localparam logic [3:0] FnSra  = 4'd7;
    localparam logic [3:0] FnOr   = 4'd8;
    localparam logic [3:0] FnAnd  = 4'd9;
    localparam logic [3:0] FnPass = 4'd10;

    localparam logic [2:0] BrNone = 3'd0;
    localparam logic [2:0] BrEq   = 3'd1;
    localparam logic [2:0] BrNe   = 3'd2;
    localparam logic [2:0] BrLt   = 3'd3;
    localparam logic [2:0] BrGe   = 3'd4;
    localparam logic [2:0] BrLtu  = 3'd5;
    localparam logic [2:0] BrGeu  = 3'd6;
    localparam logic [2:0] BrJump = 3'd7;

    logic               r_out_valid;
    logic [XLEN-1:0]    r_out_result;
    logic [XLEN-1:0]    r_out_store_data;
    logic [RADDR_W-1:0] r_out_rd_addr;
    logic               r_out_rd_we;
    logic               r_redirect_valid;
    logic [XLEN-1:0]    r_redirect_pc;

    logic [XLEN-1:0]    w_fwd_rs1;
    logic [XLEN-1:0]    w_fwd_rs2;
    logic [XLEN-1:0]    w_op1;
    logic [XLEN-1:0]    w_op2;
    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]    w_alu;
    logic               w_taken;
    logic [XLEN-1:0]    w_target;
    logic [XLEN-1:0]    w_result;
    logic               w_accept;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    // MEM is younger than WB, so it takes priority; x0 is never forwarded
    always_comb begin
        w_fwd_rs1 = in_rs1_data;
        if (fwd_mem_we && (fwd_mem_rd == in_rs1_addr) && (in_rs1_addr != '0)) begin
            w_fwd_rs1 = fwd_mem_data;
        end else if (fwd_wb_we && (fwd_wb_rd == in_rs1_addr) && (in_rs1_addr != '0)) begin
            w_fwd_rs1 = fwd_wb_data;
        end
    end

    always_comb begin
        w_fwd_rs2 = in_rs2_data;
        if (fwd_mem_we && (fwd_mem_rd == in_rs2_addr) && (in_rs2_addr != '0)) begin
            w_fwd_rs2 = fwd_mem_data;
        end else if (fwd_wb_we && (fwd_wb_rd == in_rs2_addr) && (in_rs2_addr != '0)) begin
            w_fwd_rs2 = fwd_wb_data;
        end
    end

    assign w_op1   = in_op1_pc  ? in_pc  : w_fwd_rs1;
    assign w_op2   = in_op2_imm ? in_imm : w_fwd_rs2;
    assign w_shamt = w_op2[SHAMT_W-1:0];

    always_comb begin
        w_alu = '0;
        case (in_funct)
            FnAdd:   w_alu = w_op1 + w_op2;
            FnSub:   w_alu = w_op1 - w_op2;
            FnSll:   w_alu = w_op1 << w_shamt;
            FnSlt:   w_alu = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            FnSltu:  w_alu = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            FnXor:   w_alu = w_op1 ^ w_op2;
            FnSrl:   w_alu = w_op1 >> w_shamt;
            FnSra:   w_alu = $unsigned($signed(w_op1) >>> w_shamt);
            FnOr:    w_alu = w_op1 | w_op2;
            FnAnd:   w_alu = w_op1 & w_op2;
            FnPass:  w_alu = w_op2;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (in_br_type)
            BrNone:  w_taken = 1'b0;
            BrEq:    w_taken = (w_fwd_rs1 == w_fwd_rs2);
            BrNe:    w_taken = (w_fwd_rs1 != w_fwd_rs2);
            BrLt:    w_taken = ($signed(w_fwd_rs1) < $signed(w_fwd_rs2));
            BrGe:    w_taken = ($signed(w_fwd_rs1) >= $signed(w_fwd_rs2));
            BrLtu:   w_taken = (w_fwd_rs1 < w_fwd_rs2);
            BrGeu:   w_taken = (w_fwd_rs1 >= w_fwd_rs2);
            BrJump:  w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    // JALR clears bit 0 of the computed target
    always_comb begin
        if ((in_br_type == BrJump) && in_jalr) begin
            w_target = (w_fwd_rs1 + in_imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end else begin
            w_target = in_pc + in_imm;
        end
    end

    assign w_result = (in_br_type == BrJump) ? (in_pc + XLEN'(4)) : w_alu;

    // flush beats accept and drain; redirect only ever pulses for the cycle after an accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid      <= 1'b0;
            r_out_result     <= '0;
            r_out_store_data <= '0;
            r_out_rd_addr    <= '0;
            r_out_rd_we      <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else if (flush) begin
            r_out_valid      <= 1'b0;
            r_redirect_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid      <= 1'b1;
            r_out_result     <= w_result;
            r_out_store_data <= w_fwd_rs2;
            r_out_rd_addr    <= in_rd_addr;
            r_out_rd_we      <= in_rd_we;
            r_redirect_valid <= w_taken;
            r_redirect_pc    <= w_target;
        end else begin
            r_redirect_valid <= 1'b0;
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_result     = r_out_result;
    assign out_store_data = r_out_store_data;
    assign out_rd_addr    = r_out_rd_addr;
    assign out_rd_we      = r_out_rd_we;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

endmodule
